// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration among input heads, with the output held by the winner until its tail flit transfers.
// Latency: zero. Grants, crossbar selects and out_valid are combinational from the inputs in the same cycle. Lock and pointer updates appear on the next clk edge.
// Backpressure: out_ready low on an output blocks its grant and freezes that output's lock, owner and pointer. A stalled input simply keeps its flit presented.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/head/tail[i], in_route[3i+2:3i]   flit presence, type and requested output per input
//   out_ready[o]     downstream of output o can take a flit
//   in_grant[i]      pop strobe for input i
//   out_valid[o], out_sel[3o+2:3o]             crossbar drive per output
//   out_locked[o]    output o is reserved by an in-flight packet
//   route_err        sticky flag: some head asked for a port code above 4
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int PORT_W    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS-1:0]        in_head,
  input  logic [NUM_PORTS-1:0]        in_tail,
  input  logic [NUM_PORTS*PORT_W-1:0] in_route,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        in_grant,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS*PORT_W-1:0] out_sel,
  output logic [NUM_PORTS-1:0]        out_locked,
  output logic                        route_err
);

  localparam logic [PORT_W:0]   NP   = (PORT_W+1)'(NUM_PORTS);
  localparam logic [PORT_W-1:0] LAST = PORT_W'(NUM_PORTS - 1);

  // per-output state
  logic [NUM_PORTS-1:0] locked;
  logic [PORT_W-1:0]    owner  [NUM_PORTS];
  logic [PORT_W-1:0]    rr_ptr [NUM_PORTS];

  logic [PORT_W-1:0]    route   [NUM_PORTS];
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];  // req[o][i]
  logic [NUM_PORTS-1:0] win_vld;
  logic [PORT_W-1:0]    win_idx [NUM_PORTS];
  logic [PORT_W-1:0]    src     [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] xfer_tail;
  logic [NUM_PORTS-1:0] gsrc    [NUM_PORTS];  // gsrc[i][o]: output o grants input i
  logic                 bad_head;

  // Route decode. A code above LAST matches no output, so an invalid head
  // never requests anything and just stalls at its input.
  always_comb begin
    bad_head = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = in_route[i*PORT_W +: PORT_W];
      bad_head = bad_head | (in_valid[i] & in_head[i] & (route[i] > LAST));
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        req[o][i] = in_valid[i] & in_head[i] & (route[i] == PORT_W'(o));
    end
  end

  // Round-robin pick: first requester scanning from rr_ptr upward with wrap.
  always_comb begin
    logic [PORT_W:0] idx;
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_vld[o] = 1'b0;
      win_idx[o] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = {1'b0, rr_ptr[o]} + (PORT_W+1)'(k);
        if (idx >= NP) idx = idx - NP;
        if (!win_vld[o] && req[o][idx[PORT_W-1:0]]) begin
          win_vld[o] = 1'b1;
          win_idx[o] = idx[PORT_W-1:0];
        end
      end
    end
  end

  // A locked output follows its owner's valid only; route and head of the
  // owner's flits are don't-care. Requests to a locked output are ignored,
  // so a head arriving with the releasing tail naturally waits a cycle.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (locked[o]) begin
        src[o]  = owner[o];
        xfer[o] = in_valid[owner[o]] & out_ready[o];
      end else begin
        src[o]  = win_idx[o];
        xfer[o] = win_vld[o] & out_ready[o];
      end
      xfer_tail[o] = in_tail[src[o]];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      gsrc[i] = '0;
      for (int o = 0; o < NUM_PORTS; o++)
        gsrc[i][o] = xfer[o] & (src[o] == PORT_W'(i));
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    in_grant  = '0;
    out_valid = '0;
    out_sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      in_grant[i] = ~rst & (|gsrc[i]);
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid[o] = ~rst & xfer[o];
      out_sel[o*PORT_W +: PORT_W] = rst ? '0 : src[o];
    end
  end

  assign out_locked = locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= '0;
      route_err <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      route_err <= route_err | bad_head;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (xfer[o]) begin
          if (locked[o]) begin
            if (xfer_tail[o]) locked[o] <= 1'b0;
          end else begin
            // pointer moves at the head; a single-flit packet never locks
            rr_ptr[o] <= (win_idx[o] == LAST) ? '0 : win_idx[o] + 1'b1;
            if (!xfer_tail[o]) begin
              locked[o] <= 1'b1;
              owner[o]  <= win_idx[o];
            end
          end
        end
      end
    end
  end

`ifndef SYNTHESIS
  // An input is never popped by two outputs in one cycle.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++)
        assert ($onehot0(gsrc[i]));
    end
  end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

  localparam int NP = 5;

  logic          clk;
  logic          rst;
  logic [4:0]    in_valid, in_head, in_tail, out_ready;
  logic [14:0]   in_route;
  logic [4:0]    in_grant, out_valid, out_locked;
  logic [14:0]   out_sel;
  logic          route_err;

  switch_allocator #(.NUM_PORTS(5), .PORT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .in_route(in_route), .out_ready(out_ready),
    .in_grant(in_grant), .out_valid(out_valid), .out_sel(out_sel),
    .out_locked(out_locked), .route_err(route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  grant;
    logic [4:0]  valid;
    logic [4:0]  locked;
    logic [4:0]  sel_mask;
    logic [14:0] sel;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model: owner per output (-1 = free), next-preferred input, sticky error
  int   m_own [NP];
  int   m_ptr [NP];
  bit   m_err;

  // random packet generator state per input
  int   st_len [NP];
  int   st_dst [NP];
  bit   st_go  [NP];

  logic [4:0]  g, sv, sh, stl, srdy;
  logic [14:0] sr;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [14:0] rt(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_own[o] = -1;
      m_ptr[o] = 0;
    end
    m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the response and queue it.
  task automatic apply(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                       input logic [14:0] r, input logic [4:0] rdy, output logic [4:0] gr);
    exp_t e;
    int best, bestd, d;
    @(posedge clk);
    #1;
    in_valid = v; in_head = h; in_tail = t; in_route = r; out_ready = rdy;
    e.grant = '0; e.valid = '0; e.sel = '0; e.sel_mask = '0; e.locked = '0;
    e.err = m_err;
    for (int o = 0; o < NP; o++) e.locked[o] = (m_own[o] >= 0);
    for (int o = 0; o < NP; o++) begin
      if (m_own[o] >= 0) begin
        e.sel[o*3 +: 3] = 3'(m_own[o]);
        e.sel_mask[o] = 1'b1;
        if (v[m_own[o]] && rdy[o]) begin
          e.valid[o] = 1'b1;
          e.grant[m_own[o]] = 1'b1;
          if (t[m_own[o]]) m_own[o] = -1;
        end
      end else begin
        best = -1; bestd = NP;
        for (int i = 0; i < NP; i++) begin
          if (v[i] && h[i] && int'(r[i*3 +: 3]) == o) begin
            d = (i - m_ptr[o] + NP) % NP;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
        if (best >= 0 && rdy[o]) begin
          e.valid[o] = 1'b1;
          e.grant[best] = 1'b1;
          e.sel[o*3 +: 3] = 3'(best);
          e.sel_mask[o] = 1'b1;
          m_ptr[o] = (best + 1) % NP;
          if (!t[best]) m_own[o] = best;
        end
      end
    end
    for (int i = 0; i < NP; i++)
      if (v[i] && h[i] && int'(r[i*3 +: 3]) > 4) m_err = 1'b1;
    sbq.push_back(e);
    gr = e.grant;
  endtask

  // Monitor: each cycle the driver has queued a prediction, compare it with
  // what the DUT presents mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("in_grant",   int'(in_grant),   int'(e.grant));
      chk("out_valid",  int'(out_valid),  int'(e.valid));
      chk("out_locked", int'(out_locked), int'(e.locked));
      chk("route_err",  int'(route_err),  int'(e.err));
      for (int o = 0; o < NP; o++)
        if (e.sel_mask[o]) chk($sformatf("out_sel[%0d]", o), int'(out_sel[o*3 +: 3]), int'(e.sel[o*3 +: 3]));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset held with an active head presented: outputs must stay quiet
    rst = 1'b1;
    in_valid = 5'b00001; in_head = 5'b00001; in_tail = 5'b00001;
    in_route = rt(3, 0, 0, 0, 0); out_ready = 5'b11111;
    #3;
    chk("rst_grant",  int'(in_grant),   0);
    chk("rst_valid",  int'(out_valid),  0);
    chk("rst_sel",    int'(out_sel),    0);
    chk("rst_locked", int'(out_locked), 0);
    chk("rst_err",    int'(route_err),  0);
    in_valid = '0; in_head = '0; in_tail = '0; in_route = '0;
    #9 rst = 1'b0;
    model_reset();
    for (int i = 0; i < NP; i++) begin st_len[i] = 0; st_dst[i] = 0; st_go[i] = 1'b0; end

    apply('0, '0, '0, '0, 5'b11111, g);

    // single-flit head from input 0 to port 3, then idle
    apply(5'b00001, 5'b00001, 5'b00001, rt(3, 0, 0, 0, 0), 5'b11111, g);
    apply('0, '0, '0, '0, 5'b11111, g);

    // round robin on port 0 among inputs 1, 2, 4; then 1 and 4 again
    apply(5'b10110, 5'b10110, 5'b10110, rt(0, 0, 0, 0, 0), 5'b11111, g);
    apply(5'b10100, 5'b10100, 5'b10100, rt(0, 0, 0, 0, 0), 5'b11111, g);
    apply(5'b10000, 5'b10000, 5'b10000, rt(0, 0, 0, 0, 0), 5'b11111, g);
    apply(5'b10010, 5'b10010, 5'b10010, rt(0, 0, 0, 0, 0), 5'b11111, g);
    apply(5'b10000, 5'b10000, 5'b10000, rt(0, 0, 0, 0, 0), 5'b11111, g);

    // wormhole: input 2 sends 4 flits to port 1 while input 3 waits with a head
    apply(5'b01100, 5'b01100, 5'b01000, rt(0, 0, 1, 1, 0), 5'b11111, g);
    apply(5'b01100, 5'b01000, 5'b01000, rt(0, 0, 6, 1, 0), 5'b11111, g);
    apply(5'b01100, 5'b01000, 5'b01000, rt(0, 0, 3, 1, 0), 5'b11111, g);
    apply(5'b01100, 5'b01000, 5'b01100, rt(0, 0, 0, 1, 0), 5'b11111, g);
    apply(5'b01000, 5'b01000, 5'b01000, rt(0, 0, 0, 1, 0), 5'b11111, g);
    apply('0, '0, '0, '0, 5'b11111, g);

    // backpressure: input 0 holds port 4, output blocked for 3 cycles
    apply(5'b00001, 5'b00001, 5'b00000, rt(4, 0, 0, 0, 0), 5'b11111, g);
    apply(5'b00001, 5'b00000, 5'b00000, rt(2, 0, 0, 0, 0), 5'b01111, g);
    apply(5'b00001, 5'b00000, 5'b00000, rt(2, 0, 0, 0, 0), 5'b01111, g);
    apply(5'b00001, 5'b00000, 5'b00000, rt(2, 0, 0, 0, 0), 5'b01111, g);
    apply(5'b00001, 5'b00000, 5'b00000, rt(2, 0, 0, 0, 0), 5'b11111, g);
    apply(5'b00001, 5'b00000, 5'b00001, rt(2, 0, 0, 0, 0), 5'b11111, g);
    apply('0, '0, '0, '0, 5'b11111, g);

    // invalid route code on input 1, then withdrawn
    apply(5'b00010, 5'b00010, 5'b00010, rt(0, 6, 0, 0, 0), 5'b11111, g);
    apply(5'b00010, 5'b00010, 5'b00010, rt(0, 6, 0, 0, 0), 5'b11111, g);
    apply('0, '0, '0, '0, 5'b11111, g);
    apply('0, '0, '0, '0, 5'b11111, g);

    // asynchronous reset in the middle of a packet
    apply(5'b00100, 5'b00100, 5'b00000, rt(0, 0, 1, 0, 0), 5'b11111, g);
    apply(5'b00100, 5'b00000, 5'b00000, rt(0, 0, 1, 0, 0), 5'b11111, g);
    #6 rst = 1'b1;
    #1;
    chk("arst_locked", int'(out_locked), 0);
    chk("arst_grant",  int'(in_grant),   0);
    chk("arst_valid",  int'(out_valid),  0);
    chk("arst_sel",    int'(out_sel),    0);
    chk("arst_err",    int'(route_err),  0);
    #1 rst = 1'b0;
    model_reset();
    apply(5'b00100, 5'b00100, 5'b00100, rt(0, 0, 1, 0, 0), 5'b11111, g);
    apply('0, '0, '0, '0, 5'b11111, g);

    // randomized packets of 1..4 flits, random backpressure and bubbles
    for (int c = 0; c < 3000; c++) begin
      sv = '0; sh = '0; stl = '0; sr = '0;
      for (int i = 0; i < NP; i++) begin
        if (st_len[i] == 0 && $urandom_range(0, 2) == 0) begin
          st_len[i] = $urandom_range(1, 4);
          st_dst[i] = $urandom_range(0, 4);
          st_go[i]  = 1'b0;
        end
        if (st_len[i] > 0) begin
          sv[i]  = st_go[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
          sh[i]  = ~st_go[i];
          stl[i] = (st_len[i] == 1);
          sr[i*3 +: 3] = st_go[i] ? 3'($urandom_range(0, 7)) : 3'(st_dst[i]);
        end else begin
          sh[i]  = 1'($urandom_range(0, 1));
          stl[i] = 1'($urandom_range(0, 1));
          sr[i*3 +: 3] = 3'($urandom_range(0, 7));
        end
      end
      srdy = 5'($urandom) | 5'($urandom);
      apply(sv, sh, stl, sr, srdy, g);
      for (int i = 0; i < NP; i++)
        if (g[i]) begin
          st_go[i] = 1'b1;
          st_len[i]--;
        end
    end

    apply('0, '0, '0, '0, 5'b11111, g);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
